// File: rtl/centroid_marker.sv
// Crosshair overlay on a pass-through RGB888 stream. The centroid is latched once per
// frame on the v_sync rising edge, and every output lags its input by exactly 2 cycles.
module centroid_marker #(
    parameter int          ARM   = 10,
    parameter int          THICK = 1,
    parameter logic [23:0] COLOR = 24'hFF0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        de,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [23:0] pixel_in,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        de_out,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic [23:0] pixel_out
);

    localparam logic [11:0] ARM_W   = 12'(ARM);
    localparam logic [11:0] THICK_W = 12'(THICK);

    logic [10:0] x_pos, y_pos;
    logic        line_flag;
    logic        prev_v_sync;
    logic [10:0] cx, cy;
    logic        en_l, marker_valid;

    logic [11:0] dx_c, dy_c;
    logic [11:0] dx_s1, dy_s1;
    logic        de_s1, h_sync_s1, v_sync_s1;
    logic [23:0] pixel_s1;
    logic        hit;

    function automatic logic [10:0] sat11(input logic [31:0] v);
        return (v > 32'd2047) ? 11'd2047 : v[10:0];
    endfunction

    // A 12-bit signed difference cannot wrap for 11-bit operands, so far-away
    // columns never alias back onto the marker.
    function automatic logic [11:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
        logic signed [11:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[11] ? 12'(-d) : 12'(d);
    endfunction

    // Position counters; v_sync overrides everything, de beats h_sync for x_pos.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            x_pos     <= '0;
            y_pos     <= '0;
            line_flag <= 1'b0;
        end else if (v_sync) begin
            x_pos <= '0;
            y_pos <= '0;
        end else begin
            if (h_sync) begin
                line_flag <= 1'b0;
                if (line_flag)
                    y_pos <= y_pos + 11'd1;
            end
            if (de) begin
                x_pos     <= x_pos + 11'd1;
                line_flag <= 1'b1;
            end else if (h_sync) begin
                x_pos <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_v_sync  <= 1'b0;
            cx           <= '0;
            cy           <= '0;
            en_l         <= 1'b0;
            marker_valid <= 1'b0;
        end else begin
            prev_v_sync <= v_sync;
            if (v_sync && !prev_v_sync) begin
                cx           <= sat11(x);
                cy           <= sat11(y);
                en_l         <= en;
                marker_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        dx_c = abs_diff(x_pos, cx);
        dy_c = abs_diff(y_pos, cy);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dx_s1     <= '0;
            dy_s1     <= '0;
            de_s1     <= 1'b0;
            h_sync_s1 <= 1'b0;
            v_sync_s1 <= 1'b0;
            pixel_s1  <= '0;
        end else begin
            dx_s1     <= dx_c;
            dy_s1     <= dy_c;
            de_s1     <= de;
            h_sync_s1 <= h_sync;
            v_sync_s1 <= v_sync;
            pixel_s1  <= pixel_in;
        end
    end

    always_comb begin
        hit = ((dy_s1 <= THICK_W) && (dx_s1 <= ARM_W)) ||
              ((dx_s1 <= THICK_W) && (dy_s1 <= ARM_W));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            de_out     <= 1'b0;
            h_sync_out <= 1'b0;
            v_sync_out <= 1'b0;
            pixel_out  <= '0;
        end else begin
            de_out     <= de_s1;
            h_sync_out <= h_sync_s1;
            v_sync_out <= v_sync_s1;
            pixel_out  <= (marker_valid && en_l && de_s1 && hit) ? COLOR : pixel_s1;
        end
    end

endmodule
